// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register host and its register responder.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick every CLK_DIV enabled cycles, alternating rise/fall.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic clr,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          phase;

  assign tick = ena & (cnt == CW'(CLK_DIV - 1));
  // phase=0 means the current half-period is low, so its end is a rising edge
  assign rise = tick & ~phase;
  assign fall = tick & phase;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (tick) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_reg_host.sv
// SPI mode-0 register host: one 2*REG_W-bit frame (command byte + data byte) per request.
module spi_reg_host
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = 2 * REG_W;
  localparam int BW      = $clog2(FRAME_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] DATA_BIT = BW'(REG_W);

  state_t state, state_next;

  logic               tick, rise, fall, div_clr, hs;
  logic               start, shift_rise, shift_fall, frame_done, to_idle;
  logic [REG_W-1:0]   cmd, rx_sr;
  logic [FRAME_W-1:0] tx_sr;
  logic [BW-1:0]      bit_cnt;
  logic               rw_q;

  assign hs = req_valid & req_ready & ena;

  always_comb begin
    cmd               = '0;
    cmd[REG_W-1]      = req_rw;
    cmd[ADDR_W-1:0]   = req_addr;
  end

  always_ff @(posedge clk) begin
    if (!rstb)    state <= IDLE;
    else if (ena) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs)   state_next = SETUP;
      SETUP:   if (tick) state_next = SHIFT;
      SHIFT:   if (fall && bit_cnt == LAST_BIT) state_next = HOLD;
      HOLD:    if (tick) state_next = GAP;
      GAP:     if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    start      = (state == IDLE) & hs;
    shift_rise = (state == SHIFT) & rise;
    shift_fall = (state == SHIFT) & fall;
    frame_done = (state == HOLD) & tick;
    to_idle    = (state != IDLE) & (state_next == IDLE);
  end

  // restart the divider on every state change so each phase begins with a full half-period
  assign div_clr = (state == IDLE) | (state_next != state);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .clr  (div_clr),
    .tick (tick),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      rw_q      <= RW_READ;
    end else if (ena) begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= 1'b0;
      if (start) begin
        tx_sr    <= {cmd, (req_rw == RW_WRITE) ? req_wdata : {REG_W{1'b0}}};
        rw_q     <= req_rw;
        bit_cnt  <= '0;
        spi_cs_n <= 1'b0;
        spi_clk  <= 1'b0;
        spi_mosi <= req_rw;
      end
      if (shift_rise) begin
        spi_clk <= 1'b1;
        if (bit_cnt >= DATA_BIT) rx_sr <= {rx_sr[REG_W-2:0], spi_miso};
      end
      if (shift_fall) begin
        spi_clk  <= 1'b0;
        tx_sr    <= tx_sr << 1;
        spi_mosi <= tx_sr[FRAME_W-2];
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (frame_done) begin
        spi_cs_n  <= 1'b1;
        spi_mosi  <= 1'b0;
        rsp_valid <= 1'b1;
        if (rw_q == RW_READ) rsp_rdata <= rx_sr;
      end
      // leaving for IDLE (normally from GAP, or from an illegal state) parks the pins
      if (to_idle) begin
        spi_cs_n <= 1'b1;
        spi_clk  <= 1'b0;
        spi_mosi <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_reg_host.md
SPI_REG_HOST -- requirements
Module: spi_reg_host

Interface
REQ-001 Parameter ADDR_W, default 3, register address width; SHALL be <= REG_W-1.
REQ-002 Parameter REG_W, default 8, command/data byte width; frame = 2*REG_W bits.
REQ-003 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; SHALL be >= 2.
REQ-004 clk  in  1  system clock, all logic on posedge.
REQ-005 rstb  in  1  reset, synchronous, active-low.
REQ-006 ena  in  1  global enable; when 0 all registers hold.
REQ-007 req_valid  in  1  transaction request.
REQ-008 req_ready  out  1  host can accept request.
REQ-009 req_rw  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  target register address.
REQ-011 req_wdata  in  REG_W  write data.
REQ-012 rsp_valid  out  1  one-cycle completion strobe.
REQ-013 rsp_rdata  out  REG_W  read data, MSB first as received.
REQ-014 busy  out  1  transaction in progress.
REQ-015 spi_cs_n, spi_clk, spi_mosi  out  1 each  SPI mode 0 master pins; spi_miso  in  1.

Function
REQ-016 req_ready SHALL be 1 only in state IDLE; handshake = req_valid & req_ready & ena in the same cycle.
REQ-017 On handshake, host SHALL latch rw/addr/wdata and build command byte {rw, zeros, addr}: rw in bit REG_W-1, addr in bits ADDR_W-1:0, other bits 0.
REQ-018 FSM states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; any other encoding SHALL go to IDLE.
REQ-019 SETUP: spi_cs_n=0, spi_clk=0, spi_mosi=command MSB, held for CLK_DIV cycles.
REQ-020 SHIFT: 2*REG_W bits, each = CLK_DIV cycles spi_clk=0 then CLK_DIV cycles spi_clk=1.
REQ-021 spi_mosi SHALL change only on the cycle spi_clk falls (and at SETUP entry); bit order command MSB..LSB, then wdata MSB..LSB for writes, 0 for reads.
REQ-022 On each rising spi_clk edge in data phase (bits REG_W..2*REG_W-1) host SHALL shift spi_miso into an RX register, MSB first.
REQ-023 After the last high half-period, spi_clk SHALL return to 0 and HOLD SHALL keep spi_cs_n=0 for CLK_DIV cycles.
REQ-024 GAP: spi_cs_n=1, spi_clk=0, spi_mosi=0 for CLK_DIV cycles before returning to IDLE.
REQ-025 rsp_valid SHALL pulse exactly one cycle, the first GAP cycle; for reads rsp_rdata = RX register, for writes rsp_rdata holds its previous value.
REQ-026 busy SHALL be 1 in SETUP, SHIFT, HOLD, GAP; 0 in IDLE.
REQ-027 cs_n low duration SHALL equal CLK_DIV*(4*REG_W+2) cycles (136 at defaults); request-to-request minimum = that + CLK_DIV + 1.
REQ-028 req_valid while busy SHALL be ignored (no queuing); request inputs changing mid-frame SHALL not affect the frame.
REQ-029 ena=0 mid-frame SHALL freeze divider, bit counter, pins and FSM; frame resumes unchanged when ena returns to 1.
REQ-030 spi_clk SHALL be a registered output, glitch-free, never toggling while spi_cs_n=1.

Reset
REQ-031 While rstb=0 at posedge clk: FSM=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=0, counters=0.
REQ-032 Reset mid-frame SHALL abort: spi_cs_n=1 on the first reset cycle; no rsp_valid generated.
REQ-033 req_ready SHALL rise the first cycle after rstb=1 with ena=1.

Structure
REQ-034 Package spi_reg_pkg SHALL hold the FSM state enum and constants RW_WRITE=1, RW_READ=0, shared with the register responder.
REQ-035 Sub-module spi_clk_div SHALL generate rise/fall tick pulses from CLK_DIV with a synchronous clear; the top holds FSM, shift registers and bit counter.

Verification
REQ-036 Write addr=5, wdata=0xA5, defaults -> MOSI sequence 0x85 then 0xA5 sampled on 16 rising edges; cs_n low 136 cycles; rsp_valid single pulse.
REQ-037 Read addr=3 with model driving 0x3C on MISO in data phase -> MOSI command 0x03, data bits 0, rsp_rdata=0x3C at rsp_valid.
REQ-038 Back-to-back: req_valid held high for two requests -> second accepted only after GAP; cs_n high >= 4 cycles between frames.
REQ-039 ena deasserted 10 cycles mid-SHIFT -> all pins frozen, frame completes with correct data, cs_n low 146 cycles.
REQ-040 rstb asserted at bit 7 of a write -> spi_cs_n=1 and spi_clk=0 on next cycle, no rsp_valid, next write 0x81/0x01 correct.
REQ-041 CLK_DIV=2, write addr=0, wdata=0xFF -> SCLK period 4 cycles, cs_n low 68 cycles, MOSI 0x80 then 0xFF.
